// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared constants for the multi-cycle CPU controller: ALU
//               operation codes (also used by the ALU), opcode and funct
//               field values, FSM state encoding and ALU control classes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // ALU operation codes
  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_XOR = 4'b0100;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;
  localparam logic [3:0] c_ALU_SLL = 4'b1000;
  localparam logic [3:0] c_ALU_SRL = 4'b1001;
  localparam logic [3:0] c_ALU_SRA = 4'b1010;
  localparam logic [3:0] c_ALU_LUI = 4'b1011;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // Funct field values (IR[5:0]) for R-type instructions
  localparam logic [5:0] c_FN_SLL  = 6'b000000;
  localparam logic [5:0] c_FN_SRL  = 6'b000010;
  localparam logic [5:0] c_FN_SRA  = 6'b000011;
  localparam logic [5:0] c_FN_SLLV = 6'b000100;
  localparam logic [5:0] c_FN_SRLV = 6'b000110;
  localparam logic [5:0] c_FN_SRAV = 6'b000111;
  localparam logic [5:0] c_FN_ADD  = 6'b100000;
  localparam logic [5:0] c_FN_ADDU = 6'b100001;
  localparam logic [5:0] c_FN_SUB  = 6'b100010;
  localparam logic [5:0] c_FN_SUBU = 6'b100011;
  localparam logic [5:0] c_FN_AND  = 6'b100100;
  localparam logic [5:0] c_FN_OR   = 6'b100101;
  localparam logic [5:0] c_FN_XOR  = 6'b100110;
  localparam logic [5:0] c_FN_SLT  = 6'b101010;

  // FSM state encoding
  localparam logic [3:0] c_S_FETCH    = 4'd0;
  localparam logic [3:0] c_S_DECODE   = 4'd1;
  localparam logic [3:0] c_S_EXEC_R   = 4'd2;
  localparam logic [3:0] c_S_EXEC_I   = 4'd3;
  localparam logic [3:0] c_S_MEM_ADDR = 4'd4;
  localparam logic [3:0] c_S_MEM_RD   = 4'd5;
  localparam logic [3:0] c_S_MEM_WR   = 4'd6;
  localparam logic [3:0] c_S_WB_ALU   = 4'd7;
  localparam logic [3:0] c_S_WB_MEM   = 4'd8;
  localparam logic [3:0] c_S_BRANCH   = 4'd9;
  localparam logic [3:0] c_S_JUMP     = 4'd10;
  localparam logic [3:0] c_S_ILLEGAL  = 4'd11;

  // Which family of ALU controls the current state needs
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_RTYPE  = 3'd1,
    CLS_ITYPE  = 3'd2,
    CLS_MEM    = 3'd3,
    CLS_BRANCH = 3'd4
  } alu_class_e;

  // States in which the FSM is waiting on the memory handshake
  function automatic logic is_mem_state(input logic [3:0] state);
    return (state == c_S_FETCH) || (state == c_S_MEM_RD) || (state == c_S_MEM_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational ALU control decode. Maps the current state
//               class plus opcode/funct to ALUctr, the operand selects and
//               the immediate extension mode; also flags unknown functs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  alu_class_e  i_cls,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output logic [3:0]  o_alu_ctr,
  output logic        o_alu_src_a,
  output logic        o_alu_src_b,
  output logic        o_ext_sign,
  output logic        o_funct_valid
);

  logic [3:0] w_r_ctr;
  logic       w_r_shamt;
  logic [3:0] w_i_ctr;
  logic       w_i_sign;

  // R-type funct to ALU operation; immediate shifts take the shamt operand
  always_comb begin
    w_r_ctr       = c_ALU_ADD;
    w_r_shamt     = 1'b0;
    o_funct_valid = 1'b1;
    case (i_funct)
      c_FN_ADD, c_FN_ADDU: w_r_ctr = c_ALU_ADD;
      c_FN_SUB, c_FN_SUBU: w_r_ctr = c_ALU_SUB;
      c_FN_AND:            w_r_ctr = c_ALU_AND;
      c_FN_OR:             w_r_ctr = c_ALU_OR;
      c_FN_XOR:            w_r_ctr = c_ALU_XOR;
      c_FN_SLT:            w_r_ctr = c_ALU_SLT;
      c_FN_SLL: begin
        w_r_ctr   = c_ALU_SLL;
        w_r_shamt = 1'b1;
      end
      c_FN_SRL: begin
        w_r_ctr   = c_ALU_SRL;
        w_r_shamt = 1'b1;
      end
      c_FN_SRA: begin
        w_r_ctr   = c_ALU_SRA;
        w_r_shamt = 1'b1;
      end
      c_FN_SLLV:           w_r_ctr = c_ALU_SLL;
      c_FN_SRLV:           w_r_ctr = c_ALU_SRL;
      c_FN_SRAV:           w_r_ctr = c_ALU_SRA;
      default:             o_funct_valid = 1'b0;
    endcase
  end

  // I-type opcode to ALU operation; logical immediates are zero-extended
  always_comb begin
    w_i_ctr  = c_ALU_ADD;
    w_i_sign = 1'b1;
    case (i_opcode)
      c_OP_ADDI, c_OP_ADDIU: w_i_ctr = c_ALU_ADD;
      c_OP_SLTI:             w_i_ctr = c_ALU_SLT;
      c_OP_LUI:              w_i_ctr = c_ALU_LUI;
      c_OP_ANDI: begin
        w_i_ctr  = c_ALU_AND;
        w_i_sign = 1'b0;
      end
      c_OP_ORI: begin
        w_i_ctr  = c_ALU_OR;
        w_i_sign = 1'b0;
      end
      c_OP_XORI: begin
        w_i_ctr  = c_ALU_XOR;
        w_i_sign = 1'b0;
      end
      default: ;
    endcase
  end

  // Pick the ALU control set for the class of the current state
  always_comb begin
    o_alu_ctr   = c_ALU_ADD;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 1'b0;
    o_ext_sign  = 1'b0;
    case (i_cls)
      CLS_RTYPE: begin
        o_alu_ctr   = w_r_ctr;
        o_alu_src_a = w_r_shamt;
      end
      CLS_ITYPE: begin
        o_alu_ctr   = w_i_ctr;
        o_alu_src_b = 1'b1;
        o_ext_sign  = w_i_sign;
      end
      CLS_MEM: begin
        o_alu_src_b = 1'b1;
        o_ext_sign  = 1'b1;
      end
      CLS_BRANCH: o_alu_ctr = c_ALU_SUB;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle CPU control FSM. Sequences fetch, decode,
//               execute, memory and write-back with a ready handshake to
//               memory and a sticky timeout on stalled memory accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       ALUsrcA,
  output logic       ALUsrcB,
  output logic [3:0] ALUctr,
  output logic       ext_sign,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IorD,
  output logic       IRWrite,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam int c_CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;

  logic [3:0]         state_q, state_d;
  logic [c_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic               w_mem_wait;
  logic               w_wait_last;
  alu_class_e         w_cls;
  logic [3:0]         w_alu_ctr;
  logic               w_alu_src_a;
  logic               w_alu_src_b;
  logic               w_ext_sign;
  logic               w_funct_valid;

  logic w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write;
  logic [1:0] w_pc_src;
  logic w_reg_write, w_reg_dst, w_mem_to_reg, w_instr_done, w_illegal;

  alu_op_decode u_alu_op_decode (
    .i_cls         (w_cls),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_alu_ctr     (w_alu_ctr),
    .o_alu_src_a   (w_alu_src_a),
    .o_alu_src_b   (w_alu_src_b),
    .o_ext_sign    (w_ext_sign),
    .o_funct_valid (w_funct_valid)
  );

  // Detect the last tolerated wait cycle of a stalled memory handshake
  always_comb begin
    w_mem_wait  = is_mem_state(state_q) && !mem_ready;
    w_wait_last = w_mem_wait && (int'(wait_cnt_q) == MEM_WAIT_MAX - 1);
  end

  // Next-state selection; a timeout abandons the instruction back to FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_FETCH:    if (mem_ready) state_d = c_S_DECODE;
      c_S_DECODE: begin
        case (opcode)
          c_OP_RTYPE: state_d = w_funct_valid ? c_S_EXEC_R : c_S_ILLEGAL;
          c_OP_ADDI, c_OP_ADDIU, c_OP_ANDI, c_OP_ORI,
          c_OP_XORI, c_OP_SLTI, c_OP_LUI: state_d = c_S_EXEC_I;
          c_OP_LW, c_OP_SW:   state_d = c_S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE: state_d = c_S_BRANCH;
          c_OP_J:             state_d = c_S_JUMP;
          default:            state_d = c_S_ILLEGAL;
        endcase
      end
      c_S_EXEC_R, c_S_EXEC_I: state_d = c_S_WB_ALU;
      c_S_MEM_ADDR: state_d = (opcode == c_OP_LW) ? c_S_MEM_RD : c_S_MEM_WR;
      c_S_MEM_RD:   if (mem_ready) state_d = c_S_WB_MEM;
      c_S_MEM_WR:   if (mem_ready) state_d = c_S_FETCH;
      default:      state_d = c_S_FETCH;
    endcase
    if (w_wait_last) state_d = c_S_FETCH;
  end

  // Wait counter restarts on every state change and after a timeout
  always_comb begin
    mem_timeout_d = mem_timeout_q | w_wait_last;
    if ((state_d != state_q) || w_wait_last) begin
      wait_cnt_d = '0;
    end else if (w_mem_wait) begin
      wait_cnt_d = wait_cnt_q + c_CNT_ONE;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= c_S_FETCH;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Map the current state onto the ALU control class
  always_comb begin
    case (state_q)
      c_S_EXEC_R:                           w_cls = CLS_RTYPE;
      c_S_EXEC_I:                           w_cls = CLS_ITYPE;
      c_S_MEM_ADDR, c_S_MEM_RD, c_S_MEM_WR: w_cls = CLS_MEM;
      c_S_BRANCH:                           w_cls = CLS_BRANCH;
      default:                              w_cls = CLS_NONE;
    endcase
  end

  // Moore strobes per state, gated by mem_ready and Zero where needed
  always_comb begin
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'd0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (state_q)
      c_S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      c_S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      c_S_MEM_WR: begin
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = mem_ready;
      end
      c_S_WB_ALU: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (opcode == c_OP_RTYPE);
        w_instr_done = 1'b1;
      end
      c_S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
      end
      c_S_BRANCH: begin
        w_pc_src     = 2'd1;
        w_pc_write   = (opcode == c_OP_BEQ) ? Zero : ~Zero;
        w_instr_done = 1'b1;
      end
      c_S_JUMP: begin
        w_pc_src     = 2'd2;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      c_S_ILLEGAL: w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Drive ports; everything is held at zero while reset is asserted
  always_comb begin
    ALUsrcA     = ~reset & w_alu_src_a;
    ALUsrcB     = ~reset & w_alu_src_b;
    ALUctr      = reset ? 4'd0 : w_alu_ctr;
    ext_sign    = ~reset & w_ext_sign;
    mem_read    = ~reset & w_mem_read;
    mem_write   = ~reset & w_mem_write;
    IorD        = ~reset & w_iord;
    IRWrite     = ~reset & w_ir_write;
    pc_write    = ~reset & w_pc_write;
    pc_src      = reset ? 2'd0 : w_pc_src;
    RegWrite    = ~reset & w_reg_write;
    RegDst      = ~reset & w_reg_dst;
    MemtoReg    = ~reset & w_mem_to_reg;
    instr_done  = ~reset & w_instr_done;
    illegal     = ~reset & w_illegal;
    mem_timeout = ~reset & mem_timeout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. An instruction-level
//               model expands each instruction into its expected per-cycle
//               control vectors; the bench replays them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ALUsrcA, ALUsrcB, ext_sign, mem_read, mem_write, IorD, IRWrite;
  logic       pc_write, RegWrite, RegDst, MemtoReg, instr_done, illegal, mem_timeout;
  logic [3:0] ALUctr;
  logic [1:0] pc_src;

  multicycle_ctrl #(.MEM_WAIT_MAX(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUctr(ALUctr),
    .ext_sign(ext_sign), .mem_read(mem_read), .mem_write(mem_write), .IorD(IorD),
    .IRWrite(IRWrite), .pc_write(pc_write), .pc_src(pc_src), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .instr_done(instr_done),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_ctr;
    logic       ext_sign;
    logic       mem_timeout;
  } vec_t;

  typedef struct {
    logic       rdy;
    logic       zero;
    logic [5:0] op;
    logic [5:0] fn;
    vec_t       exp;
  } step_t;

  vec_t       obs;
  step_t      q[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         tflag = 1'b0;
  logic       cur_zero = 1'b0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_fn = 6'd0;

  logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                              6'h0A, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
  logic [5:0] fn_tab [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A,
                              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};

  always_comb obs = {mem_read, mem_write, IorD, IRWrite, pc_write, pc_src, RegWrite,
                     RegDst, MemtoReg, instr_done, illegal, ALUsrcA, ALUsrcB,
                     ALUctr, ext_sign, mem_timeout};

  // ---------------- instruction-level reference model ----------------
  function automatic vec_t dflt();
    vec_t v = '0;
    v.alu_ctr = 4'b0010;
    return v;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input vec_t v);
    v.mem_timeout = tflag;
    q.push_back('{rdy, cur_zero, cur_op, cur_fn, v});
  endtask

  function automatic bit r_op(input logic [5:0] fn, output logic [3:0] ctr, output logic sa);
    sa = 1'b0;
    ctr = 4'b0010;
    case (fn)
      6'b100000, 6'b100001: ctr = 4'b0010;
      6'b100010, 6'b100011: ctr = 4'b0110;
      6'b100100: ctr = 4'b0000;
      6'b100101: ctr = 4'b0001;
      6'b100110: ctr = 4'b0100;
      6'b101010: ctr = 4'b0111;
      6'b000000: begin ctr = 4'b1000; sa = 1'b1; end
      6'b000010: begin ctr = 4'b1001; sa = 1'b1; end
      6'b000011: begin ctr = 4'b1010; sa = 1'b1; end
      6'b000100: ctr = 4'b1000;
      6'b000110: ctr = 4'b1001;
      6'b000111: ctr = 4'b1010;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic bit i_op(input logic [5:0] op, output logic [3:0] ctr, output logic ext);
    ext = 1'b1;
    ctr = 4'b0010;
    case (op)
      6'b001000, 6'b001001: ctr = 4'b0010;
      6'b001100: begin ctr = 4'b0000; ext = 1'b0; end
      6'b001101: begin ctr = 4'b0001; ext = 1'b0; end
      6'b001110: begin ctr = 4'b0100; ext = 1'b0; end
      6'b001010: ctr = 4'b0111;
      6'b001111: ctr = 4'b1011;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Fetch: every MAX_WAIT unanswered cycles trip the timeout and restart fetch
  task automatic m_fetch(input int waits);
    vec_t v;
    int   w;
    w = waits;
    v = dflt();
    v.mem_read = 1'b1;
    while (w >= MAX_WAIT) begin
      for (int i = 0; i < MAX_WAIT; i++) push(1'b0, v);
      tflag = 1'b1;
      w -= MAX_WAIT;
    end
    for (int i = 0; i < w; i++) push(1'b0, v);
    v.ir_write = 1'b1;
    v.pc_write = 1'b1;
    push(1'b1, v);
  endtask

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
    vec_t       v;
    logic [3:0] ctr;
    logic       flag;
    cur_op = op;
    cur_fn = fn;
    cur_zero = z;
    m_fetch(wf);
    push(rnd(), dflt());
    if (op == 6'b000000 && r_op(fn, ctr, flag)) begin
      v = dflt(); v.alu_ctr = ctr; v.alu_src_a = flag; push(rnd(), v);
      v = dflt(); v.reg_write = 1'b1; v.reg_dst = 1'b1; v.instr_done = 1'b1; push(rnd(), v);
    end else if (op != 6'b000000 && i_op(op, ctr, flag)) begin
      v = dflt(); v.alu_ctr = ctr; v.alu_src_b = 1'b1; v.ext_sign = flag; push(rnd(), v);
      v = dflt(); v.reg_write = 1'b1; v.instr_done = 1'b1; push(rnd(), v);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      v = dflt(); v.alu_src_b = 1'b1; v.ext_sign = 1'b1; push(rnd(), v);
      v.iord = 1'b1;
      if (op == 6'b100011) v.mem_read = 1'b1;
      else v.mem_write = 1'b1;
      if (wm >= MAX_WAIT) begin
        for (int i = 0; i < MAX_WAIT; i++) push(1'b0, v);
        tflag = 1'b1;
        return;
      end
      for (int i = 0; i < wm; i++) push(1'b0, v);
      if (op == 6'b100011) begin
        push(1'b1, v);
        v = dflt(); v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1;
        push(rnd(), v);
      end else begin
        v.instr_done = 1'b1;
        push(1'b1, v);
      end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      v = dflt(); v.alu_ctr = 4'b0110; v.pc_src = 2'd1; v.instr_done = 1'b1;
      v.pc_write = (op == 6'b000100) ? z : ~z;
      push(rnd(), v);
    end else if (op == 6'b000010) begin
      v = dflt(); v.pc_write = 1'b1; v.pc_src = 2'd2; v.instr_done = 1'b1; push(rnd(), v);
    end else begin
      v = dflt(); v.illegal = 1'b1; push(rnd(), v);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = rnd();
      #1;
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %h want 0", i, obs);
      end
    end
    tflag = 1'b0;
  endtask

  task automatic test_alu_ops();
    step_t s;
    model_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
    model_instr(6'h00, 6'h00, 1'b0, 0, 0);   // sll
    model_instr(6'h00, 6'h07, 1'b0, 0, 0);   // srav
    model_instr(6'h00, 6'h22, 1'b1, 1, 0);   // sub
    model_instr(6'h00, 6'h2A, 1'b0, 0, 0);   // slt
    model_instr(6'h08, 6'h11, 1'b0, 0, 0);   // addi
    model_instr(6'h0C, 6'h00, 1'b0, 2, 0);   // andi
    model_instr(6'h0D, 6'h00, 1'b1, 0, 0);   // ori
    model_instr(6'h0E, 6'h00, 1'b0, 0, 0);   // xori
    model_instr(6'h0A, 6'h00, 1'b0, 0, 0);   // slti
    model_instr(6'h0F, 6'h00, 1'b0, 0, 0);   // lui
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL alu_ops op=%h fn=%h step %0d: got %h want %h", s.op, s.fn, vectors, obs, s.exp);
      end
    end
  endtask

  task automatic test_memory();
    step_t s;
    model_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 wait cycles
    model_instr(6'h2B, 6'h00, 1'b0, 0, 0);   // sw
    model_instr(6'h2B, 6'h00, 1'b1, 2, 4);   // sw with waits
    model_instr(6'h23, 6'h00, 1'b0, 1, 0);   // lw
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL memory op=%h step %0d: got %h want %h", s.op, vectors, obs, s.exp);
      end
    end
  endtask

  task automatic test_branch_jump();
    step_t s;
    model_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    model_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    model_instr(6'h05, 6'h00, 1'b0, 0, 0);   // bne taken
    model_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
    model_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL branch_jump op=%h z=%b step %0d: got %h want %h", s.op, s.zero, vectors, obs, s.exp);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s;
    model_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // unknown opcode
    model_instr(6'h00, 6'h3F, 1'b0, 0, 0);   // unknown funct
    model_instr(6'h10, 6'h20, 1'b0, 0, 0);   // unknown opcode
    model_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add afterwards
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL illegal op=%h fn=%h step %0d: got %h want %h", s.op, s.fn, vectors, obs, s.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    for (int n = 0; n < 60; n++) begin
      model_instr(op_tab[$urandom_range(0, 15)], fn_tab[$urandom_range(0, 14)], rnd(),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL back_to_back op=%h fn=%h step %0d: got %h want %h", s.op, s.fn, vectors, obs, s.exp);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s;
    model_instr(6'h00, 6'h20, 1'b0, MAX_WAIT + 2, 0);   // fetch times out once
    model_instr(6'h23, 6'h00, 1'b0, 0, MAX_WAIT);       // lw aborts in MEM_RD
    model_instr(6'h2B, 6'h00, 1'b0, 0, MAX_WAIT - 1);   // longest tolerated wait
    model_instr(6'h0D, 6'h00, 1'b0, 0, 0);
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL timeout op=%h step %0d: got %h want %h", s.op, vectors, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    step_t s;
    // Run sw into MEM_WR (fetch, decode, addr, two wait cycles), then reset
    model_instr(6'h2B, 6'h00, 1'b0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL mid_write_pre step %0d: got %h want %h", vectors, obs, s.exp);
      end
    end
    q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL mid_write_reset cyc %0d: got %h want 0", i, obs);
      end
    end
    tflag = 1'b0;
    model_instr(6'h00, 6'h25, 1'b0, 0, 0);   // or, restarting from FETCH
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = s.rdy; Zero = s.zero; opcode = s.op; funct = s.fn;
      #1;
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL mid_write_post step %0d: got %h want %h", vectors, obs, s.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_memory();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
